// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read bus plus the decoder valid/ready handshake.
//   imem_req/imem_addr (fetch -> memory), imem_ack/imem_rdata (memory -> fetch),
//   instr/instr_pc/instr_valid (fetch -> decoder), instr_ready (decoder -> fetch).
interface instr_fetch_if #(parameter int ADDR_W = 8);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC + instruction-memory requester feeding a small FIFO toward the decoder.
//   clk/rst     : clock, asynchronous active-high reset
//   run         : allow new memory requests
//   redirect    : one-cycle pulse loading redirect_pc and flushing the FIFO
//   fifo_count  : FIFO occupancy
//   bus         : memory request/ack bus and decoder valid/ready handshake
module instr_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic [$clog2(DEPTH):0]  fifo_count,
  instr_fetch_if.master           bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);
  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [15:0] data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q [DEPTH];
  logic push, pop, space, empty;
  assign empty = cnt_q == '0;
  assign push = state_q == FETCH && bus.imem_ack && !redirect;
  assign bus.instr_valid = !empty && !redirect;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign cnt_nx = cnt_q + CW'(push) - CW'(pop);
  // A new request is only launched when its returning word is sure to have a slot.
  assign space = cnt_nx < CW'(DEPTH);
  assign bus.imem_req = state_q != IDLE;
  assign bus.imem_addr = addr_q;
  assign bus.instr = empty ? '0 : data_q[rd_q];
  assign bus.instr_pc = empty ? '0 : tag_q[rd_q];
  assign fifo_count = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    cnt_d = redirect ? '0 : cnt_nx;
    rd_d = redirect ? '0 : rd_q + PW'(pop);
    wr_d = redirect ? '0 : wr_q + PW'(push);
    if (redirect) begin
      // An unacked request must still complete on the bus; its data is dropped.
      pc_d = redirect_pc;
      state_d = (state_q != IDLE && !bus.imem_ack) ? DROP : run ? FETCH : IDLE;
      if (state_d != DROP) addr_d = redirect_pc;
    end else if (state_q == IDLE) begin
      if (run && space) state_d = FETCH;
    end else if (bus.imem_ack) begin
      if (state_q == FETCH) pc_d = pc_q + ADDR_W'(1);
      state_d = run && space ? FETCH : IDLE;
      addr_d = pc_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= PC0;
      addr_q <= PC0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= bus.imem_rdata;
      tag_q[wr_q] <= addr_q;
    end
  end
endmodule
